// File: rtl/seq_det_pkg.sv
// Shared types and reset defaults for the time-shared serial sequence detector.
package seq_det_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [7:0]  DEF_PATTERN = 8'b0000_1001;
  localparam int unsigned DEF_LEN     = 4;
  localparam int unsigned MIN_LEN     = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant and wraps.
module rr_arbiter #(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] last_grant,
  output logic [NCH-1:0]         gnt,
  output logic [$clog2(NCH)-1:0] idx
);

  localparam int unsigned IW = $clog2(NCH);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      cand = IW'((32'(last_grant) + k) % NCH);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Programmable sequence detector time-shared across NCH serial channels:
// one granted bit per cycle, private history per channel, one shared comparator.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned PMAX = 8,
  parameter int unsigned CNTW = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [PMAX-1:0]        cfg_pattern,
  input  logic [3:0]             cfg_len,
  input  logic                   enable,
  input  logic [NCH-1:0]         req,
  input  logic [NCH-1:0]         din,
  output logic [NCH-1:0]         gnt,
  output logic                   match,
  output logic [$clog2(NCH)-1:0] match_ch,
  output logic [CNTW-1:0]        match_cnt,
  output logic                   busy
);

  localparam int unsigned IW = $clog2(NCH);
  localparam int unsigned LW = $clog2(PMAX + 1);

  state_e          state_q, state_d;
  logic [PMAX-1:0] pattern_q, pattern_d;
  logic [LW-1:0]   len_q, len_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic [PMAX-1:0] hist_q [NCH];
  logic [PMAX-1:0] hist_d [NCH];
  logic [LW-1:0]   fill_q [NCH];
  logic [LW-1:0]   fill_d [NCH];
  logic            match_q, match_d;
  logic [IW-1:0]   match_ch_q, match_ch_d;
  logic [CNTW-1:0] match_cnt_q, match_cnt_d;

  logic [NCH-1:0]  req_run_c;
  logic [NCH-1:0]  gnt_c;
  logic [IW-1:0]   gidx_c;
  logic            accept_c;
  logic            cfg_apply_c;
  logic            hit_c;
  logic [PMAX-1:0] hist_new_c;
  logic [PMAX-1:0] mask_c;
  logic [LW-1:0]   fill_new_c;
  logic [LW-1:0]   cfg_len_c;

  // Requests are only arbitrated while running; IDLE forces gnt to zero.
  assign req_run_c = (state_q == RUN) ? req : '0;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req        (req_run_c),
    .last_grant (last_grant_q),
    .gnt        (gnt_c),
    .idx        (gidx_c)
  );

  assign accept_c    = |gnt_c;
  assign cfg_apply_c = (state_q == IDLE) && cfg_we;

  // Shared comparator evaluated on the granted channel's post-shift history.
  always_comb begin
    hist_new_c = PMAX'({hist_q[gidx_c], din[gidx_c]});
    fill_new_c = (fill_q[gidx_c] == LW'(PMAX)) ? fill_q[gidx_c] : fill_q[gidx_c] + LW'(1);
    mask_c     = (PMAX'(1) << len_q) - PMAX'(1);
    hit_c      = accept_c && (fill_new_c >= len_q) &&
                 (((hist_new_c ^ pattern_q) & mask_c) == '0);
  end

  always_comb begin
    if (32'(cfg_len) < MIN_LEN)   cfg_len_c = LW'(MIN_LEN);
    else if (32'(cfg_len) > PMAX) cfg_len_c = LW'(PMAX);
    else                          cfg_len_c = LW'(cfg_len);
  end

  always_comb begin
    state_d      = state_q;
    pattern_d    = pattern_q;
    len_d        = len_q;
    last_grant_d = last_grant_q;
    hist_d       = hist_q;
    fill_d       = fill_q;
    match_d      = hit_c;
    match_ch_d   = hit_c ? gidx_c : '0;
    match_cnt_d  = match_cnt_q;

    case (state_q)
      IDLE:    if (enable && !cfg_we) state_d = RUN;
      RUN:     if (!enable)           state_d = IDLE;
      default:                        state_d = IDLE;
    endcase

    if (cfg_apply_c) begin
      pattern_d   = cfg_pattern;
      len_d       = cfg_len_c;
      match_cnt_d = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        hist_d[i] = '0;
        fill_d[i] = '0;
      end
    end

    if (accept_c) begin
      last_grant_d   = gidx_c;
      hist_d[gidx_c] = hist_new_c;
      fill_d[gidx_c] = fill_new_c;
    end

    if (hit_c && (match_cnt_q != '1)) match_cnt_d = match_cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pattern_q    <= PMAX'(DEF_PATTERN);
      len_q        <= LW'(DEF_LEN);
      last_grant_q <= IW'(NCH - 1);
      for (int unsigned i = 0; i < NCH; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
      end
      match_q      <= 1'b0;
      match_ch_q   <= '0;
      match_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      len_q        <= len_d;
      last_grant_q <= last_grant_d;
      hist_q       <= hist_d;
      fill_q       <= fill_d;
      match_q      <= match_d;
      match_ch_q   <= match_ch_d;
      match_cnt_q  <= match_cnt_d;
    end
  end

  assign gnt       = gnt_c;
  assign match     = match_q;
  assign match_ch  = match_ch_q;
  assign match_cnt = match_cnt_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_seq_det_sched.sv
// Scoreboard bench for seq_det_sched: a behavioural model queues expected match
// channels as bits are driven; a negedge monitor pops and compares them.
module tb_seq_det_sched;

  localparam int unsigned NCH  = 4;
  localparam int unsigned PMAX = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       enable;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt, gnt2;
  logic       match, match2;
  logic [1:0] match_ch, match_ch2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  logic       busy, busy2;

  int checks = 0;
  int errors = 0;
  int sb[$];
  bit mon_en = 1'b0;

  bit m_run;
  int m_last, m_pat, m_len, m_cnt;
  int m_hist[NCH];
  int m_fill[NCH];

  seq_det_sched #(.NCH(NCH), .PMAX(PMAX), .CNTW(8)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .enable(enable), .req(req), .din(din), .gnt(gnt), .match(match), .match_ch(match_ch),
    .match_cnt(match_cnt), .busy(busy)
  );

  seq_det_sched #(.NCH(NCH), .PMAX(PMAX), .CNTW(2)) dut2 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .enable(enable), .req(req), .din(din), .gnt(gnt2), .match(match2), .match_ch(match_ch2),
    .match_cnt(match_cnt2), .busy(busy2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // Monitor: a match pulse is expected exactly when the scoreboard holds an entry.
  always @(negedge clk) begin
    logic exp_m;
    int   exp_ch;
    if (mon_en) begin
      exp_m = (sb.size() != 0);
      checks++;
      if (match !== exp_m) begin
        errors++;
        $display("FAIL sb_match: got %b expected %b at %0t", match, exp_m, $time);
      end
      if (exp_m) begin
        exp_ch = sb.pop_front();
        if (match === 1'b1) begin
          checks++;
          if (match_ch !== 2'(exp_ch)) begin
            errors++;
            $display("FAIL sb_match_ch: got %0d expected %0d at %0t", match_ch, exp_ch, $time);
          end
        end
      end
    end
  end

  task automatic model_reset();
    m_run  = 1'b0;
    m_last = NCH - 1;
    m_pat  = 'h09;
    m_len  = 4;
    m_cnt  = 0;
    for (int i = 0; i < NCH; i++) begin
      m_hist[i] = 0;
      m_fill[i] = 0;
    end
    sb.delete();
  endtask

  // One clock cycle: drive inputs, sample gnt, advance the model, queue any expected match.
  task automatic tick(input logic [3:0] r, input logic [3:0] d, input logic en,
                      input logic we, output logic [3:0] g_obs);
    logic [3:0] g_exp;
    int         w;
    int         c;
    logic       hit;
    req = r; din = d; enable = en; cfg_we = we;
    #1;
    g_obs = gnt;
    g_exp = '0;
    w     = 0;
    hit   = 1'b0;
    if (m_run) begin
      for (int k = 1; k <= NCH; k++) begin
        if (g_exp == '0 && r[(m_last + k) % NCH]) begin
          w        = (m_last + k) % NCH;
          g_exp[w] = 1'b1;
        end
      end
    end
    if (g_exp != '0) begin
      m_last    = w;
      m_hist[w] = ((m_hist[w] << 1) | int'(d[w])) & 'hFF;
      if (m_fill[w] < PMAX) m_fill[w]++;
      hit = (m_fill[w] >= m_len) && (((m_hist[w] ^ m_pat) & ((1 << m_len) - 1)) == 0);
    end
    @(posedge clk);
    if (hit) begin
      sb.push_back(w);
      if (m_cnt < 255) m_cnt++;
    end
    if (!m_run && we) begin
      c      = int'(cfg_len);
      m_pat  = int'(cfg_pattern);
      m_len  = (c < 2) ? 2 : ((c > PMAX) ? PMAX : c);
      m_cnt  = 0;
      for (int i = 0; i < NCH; i++) begin
        m_hist[i] = 0;
        m_fill[i] = 0;
      end
    end
    if (m_run) m_run = en;
    else       m_run = en && !we;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
    enable = 1'b0; req = 4'hF; din = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (gnt !== 4'h0)       begin errors++; $display("FAIL reset_gnt: got %h expected 0", gnt); end
    checks++; if (match !== 1'b0)     begin errors++; $display("FAIL reset_match: got %b expected 0", match); end
    checks++; if (match_ch !== 2'd0)  begin errors++; $display("FAIL reset_match_ch: got %0d expected 0", match_ch); end
    checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_match_cnt: got %0d expected 0", match_cnt); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL idle_gnt: got %h expected 0", gnt); end
    req    = '0;
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] g;
    logic [3:0] bits = 4'b1001;
    tick(4'b0001, 4'h0, 1'b1, 1'b0, g);
    checks++; if (g !== 4'h0)    begin errors++; $display("FAIL basic_first_gnt: got %h expected 0", g); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    for (int i = 3; i >= 0; i--) begin
      tick(4'b0001, {3'b000, bits[i]}, 1'b1, 1'b0, g);
      checks++; if (g !== 4'b0001) begin errors++; $display("FAIL basic_gnt: got %h expected 1", g); end
      checks++;
      if (match !== (i == 0)) begin errors++; $display("FAIL basic_match: bit %0d got %b expected %b", i, match, (i == 0)); end
    end
    checks++; if (match_ch !== 2'd0)  begin errors++; $display("FAIL basic_match_ch: got %0d expected 0", match_ch); end
    checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL basic_cnt: got %0d expected 1", match_cnt); end
  endtask

  task automatic test_overlap();
    logic [3:0] g;
    logic [6:0] bits = 7'b1001001;
    int         n = 0;
    tick(4'h0, 4'h0, 1'b0, 1'b0, g);
    cfg_pattern = 8'b0000_1001; cfg_len = 4'd4;
    tick(4'h0, 4'h0, 1'b0, 1'b1, g);
    tick(4'h0, 4'h0, 1'b1, 1'b0, g);
    for (int i = 6; i >= 0; i--) begin
      tick(4'b0010, {2'b00, bits[i], 1'b0}, 1'b1, 1'b0, g);
      if (match === 1'b1) n++;
    end
    checks++; if (n !== 2)             begin errors++; $display("FAIL overlap_pulses: got %0d expected 2", n); end
    checks++; if (match_cnt !== 8'd2)  begin errors++; $display("FAIL overlap_cnt: got %0d expected 2", match_cnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    int seq1[8] = '{2, 3, 0, 1, 2, 3, 0, 1};
    int seq2[6] = '{3, 0, 1, 3, 0, 1};
    for (int i = 0; i < 8; i++) begin
      tick(4'hF, 4'($urandom), 1'b1, 1'b0, g);
      checks++;
      if (g !== 4'(1 << seq1[i])) begin errors++; $display("FAIL rr_all: step %0d got %h expected ch %0d", i, g, seq1[i]); end
    end
    for (int i = 0; i < 6; i++) begin
      tick(4'b1011, 4'($urandom), 1'b1, 1'b0, g);
      checks++;
      if (g !== 4'(1 << seq2[i])) begin errors++; $display("FAIL rr_drop2: step %0d got %h expected ch %0d", i, g, seq2[i]); end
    end
    tick(4'h0, 4'h0, 1'b1, 1'b0, g);
    checks++; if (g !== 4'h0)    begin errors++; $display("FAIL rr_noreq: got %h expected 0", g); end
    tick(4'hF, 4'h0, 1'b1, 1'b0, g);
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL rr_hold_last: got %h expected 4", g); end
    checks++; if (match_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rr_cnt: got %0d expected %0d", match_cnt, m_cnt); end
  endtask

  task automatic test_fill_guard();
    logic [3:0] g;
    int exp1[5] = '{0, 0, 0, 1, 1};
    int exp2[3] = '{0, 1, 1};
    tick(4'h0, 4'h0, 1'b0, 1'b0, g);
    cfg_pattern = 8'h00; cfg_len = 4'd4;
    tick(4'h0, 4'h0, 1'b0, 1'b1, g);
    tick(4'h0, 4'h0, 1'b1, 1'b0, g);
    for (int i = 0; i < 5; i++) begin
      tick(4'b1000, 4'h0, 1'b1, 1'b0, g);
      checks++;
      if (match !== 1'(exp1[i])) begin errors++; $display("FAIL fill_len4: accept %0d got %b expected %0d", i + 1, match, exp1[i]); end
    end
    checks++; if (match_ch !== 2'd3) begin errors++; $display("FAIL fill_match_ch: got %0d expected 3", match_ch); end
    tick(4'h0, 4'h0, 1'b0, 1'b0, g);
    cfg_len = 4'd1;
    tick(4'h0, 4'h0, 1'b0, 1'b1, g);
    tick(4'h0, 4'h0, 1'b1, 1'b0, g);
    for (int i = 0; i < 3; i++) begin
      tick(4'b1000, 4'h0, 1'b1, 1'b0, g);
      checks++;
      if (match !== 1'(exp2[i])) begin errors++; $display("FAIL fill_len1: accept %0d got %b expected %0d", i + 1, match, exp2[i]); end
    end
  endtask

  task automatic test_cfg();
    logic [3:0] g;
    logic [3:0] bits = 4'b1001;
    cfg_pattern = 8'b0000_1001; cfg_len = 4'd4;
    tick(4'h0, 4'h0, 1'b1, 1'b1, g);
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL cfg_run_busy: got %b expected 1", busy); end
    checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL cfg_run_cnt: got %0d expected 2", match_cnt); end
    tick(4'b0100, 4'h0, 1'b1, 1'b0, g);
    tick(4'b0100, 4'h0, 1'b1, 1'b0, g);
    checks++; if (match !== 1'b1)     begin errors++; $display("FAIL cfg_run_ignored: got %b expected 1", match); end
    checks++; if (match_cnt !== 8'd3) begin errors++; $display("FAIL cfg_run_cnt2: got %0d expected 3", match_cnt); end
    tick(4'h0, 4'h0, 1'b0, 1'b0, g);
    tick(4'hF, 4'h0, 1'b1, 1'b1, g);
    checks++; if (g !== 4'h0)         begin errors++; $display("FAIL cfg_idle_gnt: got %h expected 0", g); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL cfg_en_busy: got %b expected 0", busy); end
    checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL cfg_en_cnt: got %0d expected 0", match_cnt); end
    tick(4'hF, 4'h0, 1'b1, 1'b0, g);
    checks++; if (g !== 4'h0)         begin errors++; $display("FAIL cfg_en_gnt: got %h expected 0", g); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL cfg_en_run: got %b expected 1", busy); end
    for (int i = 3; i >= 0; i--) tick(4'b0100, {1'b0, bits[i], 2'b00}, 1'b1, 1'b0, g);
    checks++; if (match !== 1'b1)     begin errors++; $display("FAIL cfg_new_pattern: got %b expected 1", match); end
    checks++; if (match_ch !== 2'd2)  begin errors++; $display("FAIL cfg_new_ch: got %0d expected 2", match_ch); end
  endtask

  task automatic test_saturation();
    logic [3:0] g;
    int         n = 0;
    tick(4'h0, 4'h0, 1'b0, 1'b0, g);
    cfg_pattern = 8'b0000_0011; cfg_len = 4'd2;
    tick(4'h0, 4'h0, 1'b0, 1'b1, g);
    tick(4'h0, 4'h0, 1'b1, 1'b0, g);
    for (int i = 0; i < 6; i++) begin
      tick(4'b0001, 4'b0001, 1'b1, 1'b0, g);
      if (match2 === 1'b1) n++;
    end
    checks++; if (n !== 5)             begin errors++; $display("FAIL sat_pulses: got %0d expected 5", n); end
    checks++; if (match2 !== 1'b1)     begin errors++; $display("FAIL sat_still_pulses: got %b expected 1", match2); end
    checks++; if (match_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt: got %0d expected 3", match_cnt2); end
    checks++; if (match_cnt !== 8'd5)  begin errors++; $display("FAIL sat_wide_cnt: got %0d expected 5", match_cnt); end
  endtask

  task automatic test_reset_midrun();
    logic [3:0] g;
    logic [3:0] bits = 4'b1001;
    mon_en = 1'b0;
    tick(4'b0010, 4'b0010, 1'b1, 1'b0, g);
    tick(4'b0010, 4'b0010, 1'b1, 1'b0, g);
    checks++; if (match !== 1'b1)      begin errors++; $display("FAIL rst_pending: got %b expected 1", match); end
    reset = 1'b0;
    #1;
    checks++; if (match !== 1'b0)      begin errors++; $display("FAIL rst_match: got %b expected 0", match); end
    checks++; if (match_ch !== 2'd0)   begin errors++; $display("FAIL rst_match_ch: got %0d expected 0", match_ch); end
    checks++; if (match_cnt !== 8'd0)  begin errors++; $display("FAIL rst_cnt: got %0d expected 0", match_cnt); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (gnt !== 4'h0)        begin errors++; $display("FAIL rst_gnt: got %h expected 0", gnt); end
    checks++; if (match_cnt2 !== 2'd0) begin errors++; $display("FAIL rst_cnt2: got %0d expected 0", match_cnt2); end
    checks++;
    if ({gnt2, match2, match_ch2, busy2} !== 8'h00) begin
      errors++; $display("FAIL rst_dut2: got %h expected 0", {gnt2, match2, match_ch2, busy2});
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    mon_en = 1'b1;
    tick(4'b0001, 4'h0, 1'b1, 1'b0, g);
    for (int i = 3; i >= 0; i--) begin
      tick(4'b0001, {3'b000, bits[i]}, 1'b1, 1'b0, g);
      checks++;
      if (match !== (i == 0)) begin errors++; $display("FAIL rst_default_pattern: bit %0d got %b expected %b", i, match, (i == 0)); end
    end
    checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL rst_default_cnt: got %0d expected 1", match_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_round_robin();
    test_fill_guard();
    test_cfg();
    test_saturation();
    test_reset_midrun();
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d expected matches never seen", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
